// File: rtl/huffman_tx_scheduler_if.sv
// huffman_tx_scheduler_if: symbol input, coder link and byte-stream signals of the scheduler
interface huffman_tx_scheduler_if;
    logic [6:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       flush;
    logic [6:0] coder_ascii;
    logic       coder_valid;
    logic [9:0] coder_code;
    logic [3:0] coder_len;
    logic       coder_valid_out;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic       err;
    modport master (
        input  sym_in, sym_valid, flush, coder_code, coder_len, coder_valid_out, byte_ready,
        output sym_ready, coder_ascii, coder_valid, byte_out, byte_valid, busy, err
    );
    modport slave (
        output sym_in, sym_valid, flush, coder_code, coder_len, coder_valid_out, byte_ready,
        input  sym_ready, coder_ascii, coder_valid, byte_out, byte_valid, busy, err
    );
endinterface

// File: rtl/huffman_tx_scheduler.sv
// huffman_tx_scheduler: queues symbols, issues them to the coder one at a time and packs codes MSB-first into bytes
module huffman_tx_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    huffman_tx_scheduler_if.master        bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;
    state_t        r_state, w_state_n;
    logic [6:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic [17:0]   r_acc, w_acc_n, w_app;
    logic [4:0]    r_cnt, w_cnt_n;
    logic [TW-1:0] r_timer, w_timer_n;
    logic [7:0]    r_bout;
    logic          r_fp, w_fp_n, r_err, w_err_n, r_bvalid;
    logic          w_full, w_push, w_pop, w_len_ok;
    assign w_full          = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_push          = bus.sym_valid & ~w_full;
    assign w_pop           = r_state == ISSUE;
    assign w_len_ok        = bus.coder_len != 4'd0 && bus.coder_len <= 4'd10;
    assign bus.sym_ready   = ~w_full | reset;
    assign bus.coder_valid = w_pop;
    assign bus.coder_ascii = w_pop ? r_mem[r_rp] : 7'd0;
    assign bus.byte_out    = r_bout;
    assign bus.byte_valid  = r_bvalid;
    assign bus.err         = r_err;
    assign bus.busy        = r_state != IDLE || r_count != '0 || r_fp;
    // code MSB lands at acc[17-cnt]; cnt <= 7 here so cnt+len never exceeds 17
    assign w_app = {8'd0, bus.coder_code & ((10'd1 << bus.coder_len) - 10'd1)}
                   << (5'd18 - r_cnt - {1'b0, bus.coder_len});
    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_cnt_n   = r_cnt;
        w_timer_n = r_timer;
        w_fp_n    = r_fp | bus.flush;
        w_err_n   = r_err;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_state_n = ISSUE;
                end else if (r_fp) begin
                    w_fp_n = bus.flush;
                    if (r_cnt != 5'd0) begin
                        w_cnt_n   = 5'd8;
                        w_state_n = EMIT;
                    end
                end
            end
            ISSUE: begin
                w_timer_n = '0;
                w_state_n = WAIT;
            end
            WAIT: begin
                if (bus.coder_valid_out) begin
                    w_state_n = w_len_ok ? EMIT : IDLE;
                    w_err_n   = r_err | ~w_len_ok;
                    w_acc_n   = w_len_ok ? (r_acc | w_app) : r_acc;
                    w_cnt_n   = w_len_ok ? (r_cnt + {1'b0, bus.coder_len}) : r_cnt;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_err_n   = 1'b1;
                    w_state_n = IDLE;
                end else begin
                    w_timer_n = r_timer + 1'b1;
                end
            end
            EMIT: begin
                if (r_bvalid && bus.byte_ready) begin
                    w_acc_n = r_acc << 8;
                    w_cnt_n = r_cnt - 5'd8;
                end
                if (w_cnt_n < 5'd8) w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= bus.sym_in;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_timer  <= '0;
            r_fp     <= 1'b0;
            r_err    <= 1'b0;
            r_bvalid <= 1'b0;
            r_bout   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_wp     <= r_wp + AW'(w_push);
            r_rp     <= r_rp + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_acc    <= w_acc_n;
            r_cnt    <= w_cnt_n;
            r_timer  <= w_timer_n;
            r_fp     <= w_fp_n;
            r_err    <= w_err_n;
            r_bvalid <= w_state_n == EMIT && w_cnt_n >= 5'd8;
            r_bout   <= w_acc_n[17:10];
        end
    end
endmodule

// File: tb/tb_huffman_tx_scheduler.sv
// tb_huffman_tx_scheduler: directed vectors with a small coder model and byte/issue monitors
module tb_huffman_tx_scheduler;
    localparam int TO = 15;
    logic clk, reset;
    logic [1:0] mode;
    huffman_tx_scheduler_if bus();
    huffman_tx_scheduler #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
    int n_checks = 0, n_fail = 0;
    int cyc = 0, t_cv = 0, t_err = 0, viol = 0;
    logic prev_cv = 1'b0, prev_err = 1'b0;
    logic [7:0] byte_q[$];
    logic [6:0] iss_q[$];
    logic [1:0] d_v;
    logic [6:0] d_a0, d_a1;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // coder model: answers 2 cycles after coder_valid; mode 0 map, 1 silent, 2 len 0, 3 all 0x3FF/10
    always @(posedge clk) begin
        d_v  <= reset ? 2'b00 : {d_v[0], bus.coder_valid};
        d_a0 <= bus.coder_ascii;
        d_a1 <= d_a0;
    end
    always_comb begin
        bus.coder_valid_out = d_v[1] && mode != 2'd1;
        bus.coder_code = 10'd0;
        bus.coder_len  = 4'd0;
        if (mode == 2'd3) begin
            bus.coder_code = 10'h3FF;
            bus.coder_len  = 4'd10;
        end else if (mode == 2'd0) begin
            if (d_a1 == 7'h41) begin bus.coder_code = 10'b101;   bus.coder_len = 4'd3; end
            if (d_a1 == 7'h42) begin bus.coder_code = 10'b11001; bus.coder_len = 4'd5; end
            if (d_a1 == 7'h43) begin bus.coder_code = 10'b01;    bus.coder_len = 4'd2; end
        end
    end
    always @(negedge clk) begin
        cyc++;
        if (bus.byte_valid && bus.byte_ready) byte_q.push_back(bus.byte_out);
        if (bus.coder_valid) begin iss_q.push_back(bus.coder_ascii); t_cv = cyc; end
        if (bus.coder_valid && prev_cv) viol++;
        if (bus.err && !prev_err) t_err = cyc;
        prev_cv  = bus.coder_valid;
        prev_err = bus.err;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [6:0] s);
        bus.sym_in = s;
        bus.sym_valid = 1'b1;
        tick();
        bus.sym_valid = 1'b0;
    endtask
    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask
    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 300) begin tick(); n++; end
        check(tag, 32'(n < 300), 32'd1);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        logic ok;
        logic [4:0] rdy;
        bus.sym_in = 7'd0; bus.sym_valid = 1'b0; bus.flush = 1'b0; bus.byte_ready = 1'b1;
        mode = 2'd0;
        reset = 1'b1;
        tick(); tick();
        check("rst_sym_ready", 32'(bus.sym_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
        check("rst_byte_out", 32'(bus.byte_out), 32'd0);
        check("rst_coder_valid", 32'(bus.coder_valid), 32'd0);
        reset = 1'b0;
        tick();
        // basic pack and flush, plus push-to-issue latency
        byte_q.delete();
        push(7'h41);
        @(negedge clk);
        check("lat_cv_n1", 32'(bus.coder_valid), 32'd0);
        @(negedge clk);
        check("lat_cv_n2", 32'(bus.coder_valid), 32'd1);
        check("lat_ascii", 32'(bus.coder_ascii), 32'h41);
        tick();
        push(7'h42);
        push(7'h43);
        pulse_flush();
        wait_idle("t1_idle");
        check("t1_nbytes", 32'(byte_q.size()), 32'd2);
        check("t1_b0", 32'(byte_q[0]), 32'hB9);
        check("t1_b1", 32'(byte_q[1]), 32'h40);
        check("t1_err", 32'(bus.err), 32'd0);
        // max-length codes
        byte_q.delete();
        mode = 2'd3;
        push(7'h11);
        push(7'h22);
        pulse_flush();
        wait_idle("t2_idle");
        check("t2_nbytes", 32'(byte_q.size()), 32'd3);
        check("t2_b0", 32'(byte_q[0]), 32'hFF);
        check("t2_b1", 32'(byte_q[1]), 32'hFF);
        check("t2_b2", 32'(byte_q[2]), 32'hF0);
        // back-pressure
        byte_q.delete(); iss_q.delete();
        mode = 2'd0;
        bus.byte_ready = 1'b0;
        push(7'h41); push(7'h42); push(7'h43);
        n = 0;
        while (!bus.byte_valid && n < 60) begin tick(); n++; end
        check("bp_valid", 32'(bus.byte_valid), 32'd1);
        n = iss_q.size();
        ok = 1'b1;
        repeat (5) begin
            tick();
            ok &= bus.byte_valid && bus.byte_out == 8'hB9;
        end
        check("bp_hold", 32'(ok), 32'd1);
        check("bp_no_issue", 32'(iss_q.size()), 32'(n));
        bus.byte_ready = 1'b1;
        pulse_flush();
        wait_idle("bp_idle");
        check("bp_late_issue", 32'(iss_q.size()), 32'(n + 1));
        check("bp_nbytes", 32'(byte_q.size()), 32'd2);
        check("bp_b0", 32'(byte_q[0]), 32'hB9);
        check("bp_b1", 32'(byte_q[1]), 32'h40);
        // FIFO full with a stalled coder, then timeout
        iss_q.delete();
        mode = 2'd1;
        for (int i = 0; i < 6; i++) begin
            bus.sym_in = 7'h30 + 7'(i);
            bus.sym_valid = 1'b1;
            @(negedge clk);
            if (i < 5) rdy[i] = bus.sym_ready;
            else check("full_ready6", 32'(bus.sym_ready), 32'd0);
            tick();
        end
        bus.sym_valid = 1'b0;
        check("full_ready1to5", 32'(rdy), 32'h1F);
        n = 0;
        while (!bus.err && n < 60) begin tick(); n++; end
        check("to_err", 32'(bus.err), 32'd1);
        @(negedge clk);
        #1;
        check("to_delay", 32'(t_err - t_cv), 32'(TO + 1));
        wait_idle("full_idle");
        ok = iss_q.size() == 5;
        for (int i = 0; i < 5; i++) ok &= iss_q[i] == 7'h30 + 7'(i);
        check("full_order", 32'(ok), 32'd1);
        for (int r = 0; r < 3; r++) begin
            iss_q.delete();
            for (int i = 0; i < 4; i++) push(7'h50 + 7'(r * 4 + i));
            wait_idle("wrap_idle");
            ok = iss_q.size() == 4;
            for (int i = 0; i < 4; i++) ok &= iss_q[i] == 7'h50 + 7'(r * 4 + i);
            check("wrap_order", 32'(ok), 32'd1);
        end
        check("to_err_sticky", 32'(bus.err), 32'd1);
        // illegal length keeps residual count
        do_reset();
        check("rst_err_clear", 32'(bus.err), 32'd0);
        byte_q.delete();
        mode = 2'd0;
        push(7'h41);
        wait_idle("il_idle0");
        mode = 2'd2;
        push(7'h42);
        n = 0;
        while (!bus.err && n < 30) begin tick(); n++; end
        check("il_err", 32'(bus.err), 32'd1);
        wait_idle("il_idle1");
        mode = 2'd0;
        push(7'h43);
        pulse_flush();
        wait_idle("il_idle2");
        check("il_nbytes", 32'(byte_q.size()), 32'd1);
        check("il_byte", 32'(byte_q[0]), 32'hA8);
        // reset mid-EMIT, then idle flush
        do_reset();
        bus.byte_ready = 1'b0;
        push(7'h41); push(7'h42); push(7'h43);
        n = 0;
        while (!bus.byte_valid && n < 60) begin tick(); n++; end
        check("rm_valid", 32'(bus.byte_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("rm_byte_valid", 32'(bus.byte_valid), 32'd0);
        check("rm_busy", 32'(bus.busy), 32'd0);
        check("rm_sym_ready", 32'(bus.sym_ready), 32'd1);
        reset = 1'b0;
        bus.byte_ready = 1'b1;
        byte_q.delete(); iss_q.delete();
        repeat (10) tick();
        check("rm_no_issue", 32'(iss_q.size()), 32'd0);
        pulse_flush();
        repeat (5) tick();
        check("if_nbytes", 32'(byte_q.size()), 32'd0);
        check("if_busy", 32'(bus.busy), 32'd0);
        push(7'h43);
        pulse_flush();
        wait_idle("rm_idle");
        check("rm_nbytes", 32'(byte_q.size()), 32'd1);
        check("rm_byte", 32'(byte_q[0]), 32'h40);
        check("cv_gap", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
